// File: rtl/lnc_pkg.sv
// lnc_pkg: shared FSM state type and bus slicing helper for loop_nest_counter
package lnc_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    function automatic int unsigned lvl_lsb(input int unsigned lvl, input int unsigned dw);
        return lvl * dw;
    endfunction

endpackage

// File: rtl/loop_nest_counter_level.sv
// loop_level: one loop level's index register, latched bound/stride and terminal detect (stride with LNC_STRIDE_EN)
module loop_level
    import lnc_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  clr,
    input  logic                  carry,
    input  logic [DATA_WIDTH-1:0] limit_in,
`ifdef LNC_STRIDE_EN
    input  logic [DATA_WIDTH-1:0] stride_in,
`endif
    output logic [DATA_WIDTH-1:0] val,
    output logic                  term,
    output logic                  wrap
);

    logic [DATA_WIDTH-1:0] val_q, val_d, limit_q, limit_d, inc;

`ifdef LNC_STRIDE_EN
    logic [DATA_WIDTH-1:0] stride_q, stride_d;

    // latch stride on start, folding a zero stride into one
    always_comb begin
        stride_d = load ? ((stride_in == '0) ? DATA_WIDTH'(1) : stride_in) : stride_q;
    end

    // stride register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stride_q <= '0;
        else        stride_q <= stride_d;
    end

    // terminal when the next stride would pass the bound, compared one bit wider
    always_comb begin
        term = ({1'b0, val_q} + {1'b0, stride_q}) > {1'b0, limit_q};
        inc  = val_q + stride_q;
    end
`else
    // terminal at the inclusive bound; unit increment otherwise
    always_comb begin
        term = val_q == limit_q;
        inc  = val_q + DATA_WIDTH'(1);
    end
`endif

    // index and bound next-state: load on start, zero on abort, advance on carry
    always_comb begin
        val_d   = val_q;
        limit_d = limit_q;
        if (load) begin
            limit_d = limit_in;
            val_d   = '0;
        end else if (clr) begin
            val_d = '0;
        end else if (carry) begin
            val_d = term ? '0 : inc;
        end
    end

    // index and bound registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q   <= '0;
            limit_q <= '0;
        end else begin
            val_q   <= val_d;
            limit_q <= limit_d;
        end
    end

    assign val  = val_q;
    assign wrap = carry & term;

endmodule

// File: rtl/loop_nest_counter.sv
// loop_nest_counter: N-level nested index generator with start/busy/done handshake (stride with LNC_STRIDE_EN)
module loop_nest_counter
    import lnc_pkg::*;
#(
    parameter int LEVELS     = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         start,
    input  logic                         en,
    input  logic [LEVELS*DATA_WIDTH-1:0] limit,
`ifdef LNC_STRIDE_EN
    input  logic [LEVELS*DATA_WIDTH-1:0] stride,
`endif
    output logic [LEVELS*DATA_WIDTH-1:0] val,
    output logic [LEVELS-1:0]            wrap,
    output logic                         last,
    output logic                         busy,
    output logic                         done
);

    state_e            state_q, state_d;
    logic              done_q, done_d;
    logic              step, load, acc;
    logic [LEVELS-1:0] carry, term;

    assign busy = state_q == S_RUN;
    assign step = en & busy;
    assign last = busy & (&term);
    assign load = start & ~clear & ~busy;
    assign done = done_q;

    // ripple carry: a level advances only when every inner level is terminal
    always_comb begin
        acc = step;
        for (int i = 0; i < LEVELS; i++) begin
            carry[i] = acc;
            acc      = acc & term[i];
        end
    end

    // sweep control: abort wins, start only from idle, finish on the last step
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
        end else if (state_q == S_IDLE && start) begin
            state_d = S_RUN;
        end else if (step && last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end
    end

    // state and done registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    for (genvar g = 0; g < LEVELS; g++) begin : g_level
        loop_level #(.DATA_WIDTH(DATA_WIDTH)) u_level (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load),
            .clr      (clear),
            .carry    (carry[g]),
            .limit_in (limit[lvl_lsb(g, DATA_WIDTH) +: DATA_WIDTH]),
`ifdef LNC_STRIDE_EN
            .stride_in(stride[lvl_lsb(g, DATA_WIDTH) +: DATA_WIDTH]),
`endif
            .val      (val[lvl_lsb(g, DATA_WIDTH) +: DATA_WIDTH]),
            .term     (term[g]),
            .wrap     (wrap[g])
        );
    end

endmodule

// File: tb/tb_loop_nest_counter.sv
// tb_loop_nest_counter: table, directed and randomized checks of loop_nest_counter against a mixed-radix model
module tb_loop_nest_counter;
    localparam int L  = 3;
    localparam int DW = 8;
    localparam int W  = L * DW;

    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, start = 1'b0, en = 1'b0;
    logic [W-1:0] limit = '0, stride = '0;
    logic [W-1:0] val;
    logic [L-1:0] wrap;
    logic last, busy, done;

    loop_nest_counter #(.LEVELS(L), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .start (start),
        .en    (en),
        .limit (limit),
`ifdef LNC_STRIDE_EN
        .stride(stride),
`endif
        .val   (val),
        .wrap  (wrap),
        .last  (last),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int vecs = 0, errs = 0, n_done = 0;
    int m_k[L], m_lim[L], m_s[L];
    bit m_busy, m_done;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic bit m_term(input int i);
        return m_k[i] == m_lim[i] / m_s[i];
    endfunction

    function automatic logic [W-1:0] m_val();
        logic [W-1:0] v = '0;
        for (int i = 0; i < L; i++) v[i*DW +: DW] = DW'(m_k[i] * m_s[i]);
        return v;
    endfunction

    function automatic bit m_last();
        if (!m_busy) return 1'b0;
        for (int i = 0; i < L; i++) if (!m_term(i)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [L-1:0] m_wrap(input bit e);
        logic [L-1:0] w = '0;
        bit c = e & m_busy;
        for (int i = 0; i < L; i++) begin
            w[i] = c & m_term(i);
            c    = c & m_term(i);
        end
        return w;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < L; i++) begin
            m_k[i] = 0; m_lim[i] = 0; m_s[i] = 1;
        end
        m_busy = 1'b0; m_done = 1'b0;
    endtask

    task automatic m_edge(input bit s, input bit e, input bit c, input logic [W-1:0] lv, input logic [W-1:0] sv);
        if (c) begin
            for (int i = 0; i < L; i++) m_k[i] = 0;
            m_busy = 1'b0; m_done = 1'b0;
        end else if (!m_busy && s) begin
            for (int i = 0; i < L; i++) begin
                m_lim[i] = int'(lv[i*DW +: DW]);
`ifdef LNC_STRIDE_EN
                m_s[i] = (sv[i*DW +: DW] == 0) ? 1 : int'(sv[i*DW +: DW]);
`else
                m_s[i] = 1;
`endif
                m_k[i] = 0;
            end
            m_busy = 1'b1; m_done = 1'b0;
        end else if (m_busy && e) begin
            if (m_last()) begin
                for (int i = 0; i < L; i++) m_k[i] = 0;
                m_busy = 1'b0; m_done = 1'b1;
            end else begin
                m_done = 1'b0;
                for (int i = 0; i < L; i++) begin
                    if (m_term(i)) m_k[i] = 0;
                    else begin
                        m_k[i]++;
                        break;
                    end
                end
            end
        end else begin
            m_done = 1'b0;
        end
    endtask

    task automatic tick(input bit s, input bit e, input bit c, input logic [W-1:0] lv, input logic [W-1:0] sv);
        start = s; en = e; clear = c; limit = lv; stride = sv;
        @(negedge clk);
        chk("val", val, m_val());
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("last", last, m_last());
        chk("wrap", wrap, m_wrap(e));
        if (done) n_done++;
        @(posedge clk);
        m_edge(s, e, c, lv, sv);
        #1;
    endtask

    task automatic run_sweep(input string nm, input logic [W-1:0] lv, input bit toggle, input int exp_steps);
        int steps = 0;
        n_done = 0;
        tick(1'b1, 1'b0, 1'b0, lv, '0);
        for (int c = 0; c < 400 && m_busy; c++) begin
            bit e = toggle ? (c[0] == 1'b0) : 1'b1;
            if (e) steps++;
            tick(1'b0, e, 1'b0, lv, '0);
        end
        tick(1'b0, 1'b0, 1'b0, lv, '0);
        tick(1'b0, 1'b0, 1'b0, lv, '0);
        chk({nm, " steps"}, steps, exp_steps);
        chk({nm, " done count"}, n_done, 1);
    endtask

    typedef struct {
        bit           s, e, c;
        logic [W-1:0] ev;
        bit           eb, ed;
    } vec_t;

    localparam logic [W-1:0] L213 = {8'd3, 8'd1, 8'd2};
    localparam logic [W-1:0] L203 = {8'd3, 8'd0, 8'd2};

    initial begin
        vec_t tbl[11];
        logic [W-1:0] lv, sv;
        m_reset();
        #7;
        chk("reset val", val, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset last", last, 0);
        chk("reset wrap", wrap, 0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        // limits {1,0,1}: four steps, stall, final step, ignored en, start+en, abort
        tbl[0]  = '{1, 0, 0, 24'h000000, 1, 0};
        tbl[1]  = '{0, 1, 0, 24'h000001, 1, 0};
        tbl[2]  = '{0, 0, 0, 24'h000001, 1, 0};
        tbl[3]  = '{0, 1, 0, 24'h010000, 1, 0};
        tbl[4]  = '{0, 1, 0, 24'h010001, 1, 0};
        tbl[5]  = '{0, 1, 0, 24'h000000, 0, 1};
        tbl[6]  = '{0, 1, 0, 24'h000000, 0, 0};
        tbl[7]  = '{1, 1, 0, 24'h000000, 1, 0};
        tbl[8]  = '{0, 1, 0, 24'h000001, 1, 0};
        tbl[9]  = '{1, 1, 1, 24'h000000, 0, 0};
        tbl[10] = '{0, 1, 0, 24'h000000, 0, 0};
        for (int i = 0; i < 11; i++) begin
            start = tbl[i].s; en = tbl[i].e; clear = tbl[i].c;
            limit = 24'h010001; stride = '0;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d val", i), val, tbl[i].ev);
            chk($sformatf("tbl%0d busy", i), busy, tbl[i].eb);
            chk($sformatf("tbl%0d done", i), done, tbl[i].ed);
        end
        m_reset();

        run_sweep("sweep213", L213, 1'b0, 24);
        run_sweep("stall213", L213, 1'b1, 24);
        run_sweep("sweep203", L203, 1'b0, 12);

        n_done = 0;
        tick(1'b1, 1'b0, 1'b0, L213, '0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0, L213, '0);
        tick(1'b0, 1'b1, 1'b1, L213, '0);
        tick(1'b0, 1'b0, 1'b0, L213, '0);
        chk("clear no done", n_done, 0);
        run_sweep("restart", L213, 1'b0, 24);

        tick(1'b1, 1'b0, 1'b0, L213, '0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, L213, '0);
        #1 rst_n = 1'b0;
        #1;
        chk("async val", val, 0);
        chk("async busy", busy, 0);
        chk("async done", done, 0);
        m_reset();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        tick(1'b1, 1'b1, 1'b0, L213, '0);
        tick(1'b0, 1'b0, 1'b0, L213, '0);

`ifdef LNC_STRIDE_EN
        begin
            int exp0[4] = '{0, 100, 200, 0};
            lv = {16'd0, 8'd255};
            sv = {16'd0, 8'd100};
            n_done = 0;
            tick(1'b1, 1'b0, 1'b0, lv, sv);
            chk("stride val0 0", val[7:0], exp0[0]);
            for (int i = 1; i < 4; i++) begin
                tick(1'b0, 1'b1, 1'b0, lv, sv);
                chk($sformatf("stride val0 %0d", i), val[7:0], exp0[i]);
            end
            tick(1'b0, 1'b0, 1'b0, lv, sv);
            chk("stride done count", n_done, 1);
        end
`endif

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < L; i++) begin
                lv[i*DW +: DW] = DW'($urandom_range(0, 3));
                sv[i*DW +: DW] = DW'($urandom_range(0, 3));
            end
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, lv, sv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
